// File: rtl/iq_settle_fsm.sv
// Start/settling controller for the IQ compensation stage: trains, watches Wr/Wj
// over fixed windows, then freezes the coefficients on lock or after a bounded timeout.
module iq_settle_fsm #(
  parameter int W_WIDTH   = 13,
  parameter int TRAIN_LEN = 32,
  parameter int WIN_LOG2  = 6,
  parameter int TOL       = 4,
  parameter int MAX_WIN   = 8
) (
  input  logic                      clk,
  input  logic                      RESET,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      sample_en,
  input  logic signed [W_WIDTH-1:0] Wr,
  input  logic signed [W_WIDTH-1:0] Wj,
  output logic                      freeze_iqcomp,
  output logic                      locked,
  output logic                      timeout,
  output logic                      busy,
  output logic [7:0]                win_count
);

  // state   | meaning
  // IDLE    | waiting for start
  // TRAIN   | ignoring TRAIN_LEN samples while the compensator converges
  // TRACK   | measuring Wr/Wj span over one window
  // LOCKED  | spans within TOL, coefficients frozen
  // TIMEOUT | MAX_WIN windows failed, coefficients frozen anyway
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRAIN   = 3'd1;
  localparam logic [2:0] S_TRACK   = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_TIMEOUT = 3'd4;

  localparam int unsigned WP1 = W_WIDTH + 1;
  localparam int          WIN_LEN = 1 << WIN_LOG2;
  localparam logic [8:0]  TRAIN_LAST = 9'(TRAIN_LEN - 1);
  localparam logic [8:0]  WIN_LAST   = 9'(WIN_LEN - 1);
  localparam logic [7:0]  MAX_WIN_C  = 8'(MAX_WIN);
  localparam logic signed [W_WIDTH:0] TOL_S = WP1'(TOL);

  logic [2:0]                r_state;
  logic [8:0]                r_cnt;
  logic [7:0]                r_win_cnt;
  logic signed [W_WIDTH-1:0] r_min_r, r_max_r, r_min_j, r_max_j;

  logic [2:0]                w_state_nxt;
  logic [8:0]                w_cnt_nxt;
  logic [7:0]                w_win_nxt;
  logic [7:0]                w_win_inc;
  logic                      w_first;
  logic                      w_stable;
  logic signed [W_WIDTH-1:0] w_min_r, w_max_r, w_min_j, w_max_j;
  logic signed [W_WIDTH:0]   w_span_r, w_span_j;

  // Window extremes including the current sample, so the decision sees it.
  always_comb begin
    w_first  = (r_cnt == 9'd0);
    w_min_r  = (w_first || (Wr < r_min_r)) ? Wr : r_min_r;
    w_max_r  = (w_first || (Wr > r_max_r)) ? Wr : r_max_r;
    w_min_j  = (w_first || (Wj < r_min_j)) ? Wj : r_min_j;
    w_max_j  = (w_first || (Wj > r_max_j)) ? Wj : r_max_j;
    w_span_r = {w_max_r[W_WIDTH-1], w_max_r} - {w_min_r[W_WIDTH-1], w_min_r};
    w_span_j = {w_max_j[W_WIDTH-1], w_max_j} - {w_min_j[W_WIDTH-1], w_min_j};
    w_stable = (w_span_r <= TOL_S) && (w_span_j <= TOL_S);
    w_win_inc = r_win_cnt + 8'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_win_nxt   = r_win_cnt;
    case (r_state)
      S_IDLE, S_LOCKED, S_TIMEOUT: begin
        if (start) begin
          w_state_nxt = S_TRAIN;
          w_cnt_nxt   = 9'd0;
          w_win_nxt   = 8'd0;
        end
      end
      S_TRAIN: begin
        if (sample_en) begin
          if (r_cnt == TRAIN_LAST) begin
            w_state_nxt = S_TRACK;
            w_cnt_nxt   = 9'd0;
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      S_TRACK: begin
        if (sample_en) begin
          if (r_cnt == WIN_LAST) begin
            w_cnt_nxt = 9'd0;
            if (w_stable) begin
              w_state_nxt = S_LOCKED;
            end else begin
              w_win_nxt = w_win_inc;
              if (w_win_inc == MAX_WIN_C) w_state_nxt = S_TIMEOUT;
            end
          end else begin
            w_cnt_nxt = r_cnt + 9'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 9'd0;
      w_win_nxt   = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_cnt         <= 9'd0;
      r_win_cnt     <= 8'd0;
      r_min_r       <= '0;
      r_max_r       <= '0;
      r_min_j       <= '0;
      r_max_j       <= '0;
      freeze_iqcomp <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_win_cnt <= w_win_nxt;
      if (r_state == S_TRACK && sample_en) begin
        r_min_r <= w_min_r;
        r_max_r <= w_max_r;
        r_min_j <= w_min_j;
        r_max_j <= w_max_j;
      end
      freeze_iqcomp <= (w_state_nxt == S_LOCKED) || (w_state_nxt == S_TIMEOUT);
      locked        <= (w_state_nxt == S_LOCKED);
      timeout       <= (w_state_nxt == S_TIMEOUT);
      busy          <= (w_state_nxt == S_TRAIN) || (w_state_nxt == S_TRACK);
    end
  end

  assign win_count = r_win_cnt;

endmodule

// File: tb/tb_iq_settle_fsm.sv
// Directed bench for iq_settle_fsm with default parameters; expected values are
// worked out by hand from the edge numbering relative to the start edge E0.
module tb_iq_settle_fsm;
  logic               clk = 1'b0;
  logic               RESET = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               sample_en = 1'b0;
  logic signed [12:0] Wr = 13'sd0;
  logic signed [12:0] Wj = 13'sd0;
  logic               freeze_iqcomp, locked, timeout, busy;
  logic [7:0]         win_count;

  int total = 0;
  int bad = 0;
  logic               alt_en = 1'b0;
  logic               half_en = 1'b0;
  logic signed [12:0] va = 13'sd0;
  logic signed [12:0] vb = 13'sd0;

  iq_settle_fsm dut (
    .clk(clk), .RESET(RESET), .start(start), .abort(abort), .sample_en(sample_en),
    .Wr(Wr), .Wj(Wj), .freeze_iqcomp(freeze_iqcomp), .locked(locked),
    .timeout(timeout), .busy(busy), .win_count(win_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1ns after the last; patterns update after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (alt_en) Wr = (Wr == va) ? vb : va;
      if (half_en) sample_en = ~sample_en;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start so that the next edge is E0; returns 1ns after E0.
  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_freeze", {31'd0, freeze_iqcomp}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_win", {24'd0, win_count}, 0);
    #10 RESET = 1'b0;
    step(3);
    check("idle_busy", {31'd0, busy}, 0);

    // Constant coefficients: lock at E0+96
    Wr = 13'sd100; Wj = -13'sd50; sample_en = 1'b1;
    do_start();
    check("c_busy_e0", {31'd0, busy}, 1);
    step(95);
    check("c_busy_e95", {31'd0, busy}, 1);
    check("c_frz_e95", {31'd0, freeze_iqcomp}, 0);
    step(1);
    check("c_frz_e96", {31'd0, freeze_iqcomp}, 1);
    check("c_lock_e96", {31'd0, locked}, 1);
    check("c_busy_e96", {31'd0, busy}, 0);
    check("c_win_e96", {24'd0, win_count}, 0);

    // Start from LOCKED; Wr 100/104 is exactly TOL
    va = 13'sd100; vb = 13'sd104; Wr = va; Wj = 13'sd0; alt_en = 1'b1;
    do_start();
    check("s_frz_drop", {31'd0, freeze_iqcomp}, 0);
    check("s_lock_drop", {31'd0, locked}, 0);
    check("s_busy", {31'd0, busy}, 1);
    step(95);
    check("t_lock_e95", {31'd0, locked}, 0);
    step(1);
    check("t_lock_e96", {31'd0, locked}, 1);

    // Wr 100/105: span 5 never locks, timeout at E0+544
    vb = 13'sd105;
    do_start();
    step(96);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step(64);
      check($sformatf("o_win_%0d", k), {24'd0, win_count}, k);
      check($sformatf("o_tmo_%0d", k), {31'd0, timeout}, (k == 8) ? 1 : 0);
    end
    check("o_frz", {31'd0, freeze_iqcomp}, 1);
    check("o_lock", {31'd0, locked}, 0);
    check("o_busy", {31'd0, busy}, 0);
    step(10);
    check("o_win_hold", {24'd0, win_count}, 8);

    // Full-scale swing: span 8191 must not wrap into a lock
    va = 13'sd4095; vb = -13'sd4096; Wr = va;
    do_start();
    check("f_win_clr", {24'd0, win_count}, 0);
    step(96);
    check("f_win1", {24'd0, win_count}, 1);
    check("f_lock1", {31'd0, locked}, 0);
    step(447);
    check("f_tmo_e543", {31'd0, timeout}, 0);
    step(1);
    check("f_tmo_e544", {31'd0, timeout}, 1);
    check("f_lock_e544", {31'd0, locked}, 0);

    // Half-rate sample_en: samples on odd edges, 96th sample at E0+191
    alt_en = 1'b0; Wr = 13'sd7; Wj = 13'sd3; sample_en = 1'b0; half_en = 1'b1;
    do_start();
    step(190);
    check("h_lock_e190", {31'd0, locked}, 0);
    check("h_busy_e190", {31'd0, busy}, 1);
    step(1);
    check("h_lock_e191", {31'd0, locked}, 1);
    half_en = 1'b0; sample_en = 1'b1;

    // Abort mid-TRACK after one failed window
    va = 13'sd100; vb = 13'sd105; Wr = va; alt_en = 1'b1;
    do_start();
    step(100);
    check("a_win_pre", {24'd0, win_count}, 1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("a_busy", {31'd0, busy}, 0);
    check("a_frz", {31'd0, freeze_iqcomp}, 0);
    check("a_win", {24'd0, win_count}, 0);
    step(5);
    check("a_idle", {31'd0, busy}, 0);

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", {31'd0, busy}, 0);

    // Asynchronous reset mid-TRACK
    do_start();
    step(100);
    check("r_busy_pre", {31'd0, busy}, 1);
    #2 RESET = 1'b1;
    #1;
    check("r_busy", {31'd0, busy}, 0);
    check("r_win", {24'd0, win_count}, 0);
    check("r_frz", {31'd0, freeze_iqcomp}, 0);
    #2 RESET = 1'b0;
    step(10);
    check("r_idle", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
